regfile_arbiter: RTL and testbench

//  Shares the single-port register file (one address, one write enable, combinational read) between two

---
 rtl/regfile_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port register file.
// Supports locked read-modify-write sequences, a lock watchdog and illegal-address rejection.
module regfile_arbiter #(
    parameter int n            = 8,
    parameter int addr_width   = 5,
    parameter int regcount     = 10,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic                  lock_a,
    input  logic [addr_width-1:0] addr_a,
    input  logic [n-1:0]          wdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic                  lock_b,
    input  logic [addr_width-1:0] addr_b,
    input  logic [n-1:0]          wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [n-1:0]          rdata_a,
    output logic [n-1:0]          rdata_b,
    output logic                  err_a,
    output logic                  err_b,
    output logic                  rf_we,
    output logic [addr_width-1:0] rf_addr,
    output logic [n-1:0]          rf_wdata,
    input  logic [n-1:0]          rf_rdata
);
    typedef enum logic [1:0] {UNLOCKED, LOCKED_A, LOCKED_B} state_t;

    localparam int WDW = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(LOCK_TIMEOUT - 1);
    localparam logic [addr_width:0] REGCOUNT_W = (addr_width + 1)'(regcount);

    state_t                state, state_nxt;
    logic                  last_b, last_b_nxt;   // 1 when B won the most recent grant
    logic [WDW-1:0]        wdog, wdog_nxt;
    logic                  err_a_nxt, err_b_nxt;
    logic                  granted, legal, we_w, lock_w;
    logic [addr_width-1:0] addr_w;
    logic [n-1:0]          wdata_w;

    // Grants are combinational; reset gates them so everything is quiet while nReset is low.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        unique case (state)
            LOCKED_A: gnt_a = req_a;
            LOCKED_B: gnt_b = req_b;
            default: begin
                if (req_a && req_b) begin
                    gnt_a = last_b;
                    gnt_b = !last_b;
                end else begin
                    gnt_a = req_a;
                    gnt_b = req_b;
                end
            end
        endcase
        if (!nReset) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    assign granted  = gnt_a | gnt_b;
    assign addr_w   = gnt_b ? addr_b  : addr_a;
    assign wdata_w  = gnt_b ? wdata_b : wdata_a;
    assign we_w     = gnt_b ? we_b    : we_a;
    assign lock_w   = gnt_b ? lock_b  : lock_a;
    assign legal    = {1'b0, addr_w} < REGCOUNT_W;

    assign rf_we    = granted & we_w & legal;
    assign rf_addr  = granted ? addr_w  : '0;
    assign rf_wdata = granted ? wdata_w : '0;

    always_comb begin
        state_nxt  = state;
        last_b_nxt = last_b;
        wdog_nxt   = '0;
        err_a_nxt  = 1'b0;
        err_b_nxt  = 1'b0;
        if (granted) begin
            last_b_nxt = gnt_b;
            err_a_nxt  = gnt_a & !legal;
            err_b_nxt  = gnt_b & !legal;
            // An illegal-address access neither takes nor releases the lock.
            if (legal) begin
                if (state == UNLOCKED && lock_w)
                    state_nxt = gnt_b ? LOCKED_B : LOCKED_A;
                else if (state != UNLOCKED && !lock_w)
                    state_nxt = UNLOCKED;
            end
        end else if (state != UNLOCKED) begin
            if (wdog == WD_LAST) begin
                state_nxt  = UNLOCKED;
                last_b_nxt = (state == LOCKED_B);
                err_a_nxt  = (state == LOCKED_A);
                err_b_nxt  = (state == LOCKED_B);
            end else begin
                wdog_nxt = wdog + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= UNLOCKED;
            last_b   <= 1'b1;
            wdog     <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
            err_a    <= 1'b0;
            err_b    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state    <= state_nxt;
            last_b   <= last_b_nxt;
            wdog     <= wdog_nxt;
            rvalid_a <= gnt_a & !we_w;
            rvalid_b <= gnt_b & !we_w;
            err_a    <= err_a_nxt;
            err_b    <= err_b_nxt;
            if (gnt_a && !we_w) rdata_a <= legal ? rf_rdata : '0;
            if (gnt_b && !we_w) rdata_b <= legal ? rf_rdata : '0;
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized and directed bench for regfile_arbiter against a transaction-level model
// (lock owner, idle count, preferred requester, shadow register array).
module tb_regfile_arbiter;
    localparam int N  = 8;
    localparam int AW = 5;
    localparam int RC = 10;
    localparam int LT = 16;

    logic          Clock = 1'b0;
    logic          nReset;
    logic          req_a, we_a, lock_a, req_b, we_b, lock_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [N-1:0]  wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b;
    logic [N-1:0]  rdata_a, rdata_b;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [N-1:0]  rf_wdata, rf_rdata;

    regfile_arbiter #(.n(N), .addr_width(AW), .regcount(RC), .LOCK_TIMEOUT(LT)) dut (
        .Clock(Clock), .nReset(nReset),
        .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .err_a(err_a), .err_b(err_b),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 Clock = ~Clock;

    // Register file the arbiter drives: combinational read, write at the clock edge.
    logic [N-1:0] rf_mem [2**AW];
    assign rf_rdata = (int'(rf_addr) < RC) ? rf_mem[rf_addr] : '0;
    always @(posedge Clock) if (rf_we) rf_mem[rf_addr] <= rf_wdata;

    // Reference model state.
    int           owner;    // -1 none, 0 A, 1 B
    int           prefer;   // requester that wins the next contention
    int           idle;
    logic [N-1:0] mmem [RC];
    bit           e_rv_a, e_rv_b, e_err_a, e_err_b;
    logic [N-1:0] e_rd_a, e_rd_b;
    bit           seen_a, seen_b, seen_we;
    int           total = 0;
    int           bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_a(input bit we, input bit lk, input int ad, input int wd);
        req_a = 1'b1; we_a = we; lock_a = lk; addr_a = AW'(ad); wdata_a = N'(wd);
    endtask

    task automatic set_b(input bit we, input bit lk, input int ad, input int wd);
        req_b = 1'b1; we_b = we; lock_b = lk; addr_b = AW'(ad); wdata_b = N'(wd);
    endtask

    // One clock cycle: inputs already driven just after a falling edge.
    task automatic tick();
        bit ga, gb, wx, lx, legal;
        int x;
        logic [AW-1:0] ad;
        logic [N-1:0]  wd;
        #1;
        ga = 0; gb = 0;
        if (owner == 0)                ga = req_a;
        else if (owner == 1)           gb = req_b;
        else if (req_a && req_b) begin ga = (prefer == 0); gb = !ga; end
        else begin                     ga = req_a; gb = req_b; end
        check("gnt_a", gnt_a, ga);
        check("gnt_b", gnt_b, gb);
        seen_a = gnt_a; seen_b = gnt_b; seen_we = rf_we;
        e_rv_a = 0; e_rv_b = 0; e_err_a = 0; e_err_b = 0;
        if (ga || gb) begin
            x  = ga ? 0 : 1;
            ad = ga ? addr_a : addr_b;
            wd = ga ? wdata_a : wdata_b;
            wx = ga ? we_a : we_b;
            lx = ga ? lock_a : lock_b;
            legal = int'(ad) < RC;
            check("rf_we", rf_we, wx && legal);
            check("rf_addr", rf_addr, ad);
            check("rf_wdata", rf_wdata, wd);
            if (!wx) begin
                if (x == 0) begin e_rv_a = 1; e_rd_a = legal ? mmem[ad] : '0; end
                else        begin e_rv_b = 1; e_rd_b = legal ? mmem[ad] : '0; end
            end else if (legal) begin
                mmem[ad] = wd;
            end
            if (!legal) begin
                if (x == 0) e_err_a = 1; else e_err_b = 1;
            end
            prefer = 1 - x;
            idle   = 0;
            if (legal) begin
                if (owner < 0 && lx)        owner = x;
                else if (owner == x && !lx) owner = -1;
            end
        end else begin
            check("rf_idle", {rf_we, rf_addr, rf_wdata}, 0);
            if (owner >= 0) begin
                idle++;
                if (idle == LT) begin
                    if (owner == 0) e_err_a = 1; else e_err_b = 1;
                    prefer = 1 - owner;
                    owner  = -1;
                    idle   = 0;
                end
            end
        end
        @(negedge Clock);
        if (ga) req_a = 1'b0;
        if (gb) req_b = 1'b0;
        check("rvalid_a", rvalid_a, e_rv_a);
        check("rvalid_b", rvalid_b, e_rv_b);
        check("rdata_a", rdata_a, e_rd_a);
        check("rdata_b", rdata_b, e_rd_b);
        check("err_a", err_a, e_err_a);
        check("err_b", err_b, e_err_b);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        #1;
        check("rst_gnt", {gnt_a, gnt_b}, 0);
        check("rst_pulses", {rvalid_a, rvalid_b, err_a, err_b}, 0);
        check("rst_rdata", {rdata_a, rdata_b}, 0);
        check("rst_rf", {rf_we, rf_addr, rf_wdata}, 0);
        owner = -1; prefer = 0; idle = 0;
        e_rv_a = 0; e_rv_b = 0; e_err_a = 0; e_err_b = 0;
        e_rd_a = '0; e_rd_b = '0;
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waits, err_at, t;
        nReset = 1'b0;
        req_a = 0; we_a = 0; lock_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; lock_b = 0; addr_b = '0; wdata_b = '0;
        for (int i = 0; i < 2**AW; i++) rf_mem[i] = N'($urandom);
        for (int i = 0; i < RC; i++) mmem[i] = rf_mem[i];
        @(negedge Clock);
        do_reset();

        // Both read addr 3 right after reset: A first, then B.
        set_a(0, 0, 3, 0); set_b(0, 0, 3, 0);
        tick();
        check("t1_a_first", seen_a, 1);
        check("t1_rvalid_a", rvalid_a, 1);
        tick();
        check("t1_b_second", seen_b, 1);
        check("t1_rvalid_b", rvalid_b, 1);

        // Write then read-back in the following cycle.
        set_a(1, 0, 7, 'h5A);
        tick();
        set_b(0, 0, 7, 0);
        tick();
        check("t2_rdata_b", {rvalid_b, rdata_b}, {1'b1, 8'h5A});

        // Write to an unimplemented address.
        set_a(1, 0, 12, 'hC3);
        tick();
        check("t3_rf_we", seen_we, 0);
        check("t3_err_a", err_a, 1);
        set_b(0, 0, 12, 0);
        tick();
        check("t3_rd_illegal", {rvalid_b, rdata_b, err_b}, {1'b1, 8'h00, 1'b1});

        // Locked read-modify-write holds B off until the unlocking write.
        set_a(0, 1, 2, 0); set_b(0, 0, 2, 0);
        tick();
        check("t4_lock_gnt", seen_a, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_b_blocked", seen_b, 0);
        end
        set_a(1, 0, 2, 'h77);
        tick();
        check("t4_unlock_wr", {seen_a, seen_b}, 2'b10);
        tick();
        check("t4_b_after", seen_b, 1);
        check("t4_b_data", rdata_b, 8'h77);

        // Lock held by an idle A: watchdog releases it.
        set_a(0, 1, 4, 0);
        tick();
        set_b(0, 0, 1, 0);
        waits = -1; err_at = -1; t = 0;
        while (t < 40) begin
            t++;
            tick();
            if (err_a) err_at = t;
            if (seen_b) begin waits = t - 1; break; end
        end
        check("t5_waits", waits, LT);
        check("t5_err_at", err_at, LT);

        // Reset while locked with a read result pending.
        set_a(0, 1, 2, 0);
        tick();
        check("t6_rvalid_pending", rvalid_a, 1);
        set_a(0, 0, 4, 0); set_b(0, 0, 5, 0);
        do_reset();
        tick();
        check("t6_a_first", seen_a, 1);
        tick();
        check("t6_b_next", seen_b, 1);

        // Random traffic, occasional illegal addresses, locks and abandoned requests.
        repeat (1500) begin
            if (!req_a) begin
                if ($urandom_range(0, 9) < 4)
                    set_a(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                          $urandom_range(0, 13), $urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                req_a = 1'b0;
            end
            if (!req_b) begin
                if ($urandom_range(0, 9) < 4)
                    set_b(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                          $urandom_range(0, 13), $urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                req_b = 1'b0;
            end
            tick();
        end

        // Read every register back through A.
        req_b = 1'b0;
        for (int i = 0; i < RC; i++) begin
            set_a(0, 0, i, 0);
            for (int k = 0; k < 40 && req_a; k++) tick();
            check("readback_gnt", req_a, 0);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
